icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter NSETS, default 16, number of direct-mapped one-word lines (power of two, 2..1024).
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 The block SHALL have port imemaddr  input  32  datapath byte address (PC).
REQ-006 The block SHALL have port ihit  output  1  requested word valid this cycle.
REQ-007 The block SHALL have port imemload  output  32  instruction word returned to fetch stage.
REQ-008 The block SHALL have port iREN  output  1  read request to memory arbiter.
REQ-009 The block SHALL have port iaddr  output  32  word-aligned address to memory arbiter.
REQ-010 The block SHALL have port iwait  input  1  arbiter busy; fill data valid in a cycle where iREN=1 and iwait=0.
REQ-011 The block SHALL have port iload  input  32  fill data from arbiter.

Function
REQ-012 The block SHALL decompose an address as offset[1:0] (ignored), index[log2(NSETS)+1:2], tag = remaining upper bits.
REQ-013 The block SHALL hold per line: valid bit, tag, 32-bit data word.
REQ-014 The block SHALL implement FSM states IDLE and FETCH.
REQ-015 In IDLE, ihit SHALL be combinational: imemREN AND valid[index] AND tag match; imemload = data[index] when ihit=1, else 32'h0.
REQ-016 In IDLE with imemREN=1 and no hit, the block SHALL latch {tag,index} of imemaddr and go to FETCH on the next edge.
REQ-017 In FETCH, iREN SHALL be 1 and iaddr SHALL be the latched address with bits[1:0]=0; ihit SHALL be 0 regardless of imemaddr.
REQ-018 In FETCH with iwait=0, on that edge the block SHALL write iload, latched tag and valid=1 into the latched index and return to IDLE.
REQ-019 In FETCH with iwait=1, the block SHALL remain in FETCH holding iREN and iaddr stable.
REQ-020 A fill SHALL complete even if imemREN drops or imemaddr changes (branch/flush) during FETCH; the new address is looked up in IDLE afterwards.
REQ-021 In IDLE, iREN SHALL be 0 and iaddr SHALL be 32'h0.
REQ-022 Latency: hit = 0 cycles (same cycle); miss with arbiter latency L cycles of iwait=1 = L+2 cycles from request to ihit.
REQ-023 A fill to an occupied index SHALL overwrite the prior line (conflict eviction); no other line changes.
REQ-024 The block SHALL never write lines except by fill; it is read-only to the datapath.

Reset
REQ-025 On nRST=0, asynchronously: all valid bits 0, state IDLE, latched address 0; outputs ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-026 Reset during FETCH SHALL abandon the fill; the target line SHALL remain invalid.
REQ-027 Tag and data arrays need not be reset.

Configuration
REQ-028 With macro ICACHE_STATS_EN defined, the block SHALL add outputs hit_count (32) and miss_count (32), reset to 0.
REQ-029 With ICACHE_STATS_EN, hit_count SHALL increment on each cycle with ihit=1; miss_count SHALL increment on each IDLE->FETCH transition; both wrap modulo 2^32.
REQ-030 Without ICACHE_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then iload=0x2401_0005 -> iREN=1 with iaddr=0x40 for 4 cycles, ihit=1 with imemload=0x2401_0005 exactly 5 cycles after request.
REQ-032 Repeat hit: after REQ-031 fill, imemaddr=0x0000_0042 -> ihit=1 same cycle, imemload=0x2401_0005, iREN=0.
REQ-033 Conflict: with NSETS=16, fill 0x40 then request 0x0000_0080 (same index, new tag) -> miss, fill, then 0x40 misses again.
REQ-034 Redirect mid-miss: miss on 0x100, change imemaddr to 0x200 while iwait=1 -> iaddr stays 0x100, line 0x100 filled, then FETCH of 0x200 begins.
REQ-035 Reset mid-fill: nRST low during FETCH -> iREN=0 immediately, later request to same address misses.
REQ-036 Stats (ICACHE_STATS_EN): run REQ-031 then REQ-032 for 3 cycles -> miss_count=1, hit_count=4.

Source files
------------

// File: rtl/icache_if.sv
// Instruction-cache bus bundle: datapath fetch port (imemREN/imemaddr/ihit/imemload)
// and memory-arbiter fill port (iREN/iaddr/iwait/iload).
// slave  = the cache's view, master = the fetch stage / arbiter side (testbench).
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a two-state fill FSM.
// Hits return in the same cycle. A miss latches {tag,index} and issues a word
// read to the arbiter until iwait drops, then writes the line and goes back
// to IDLE, where the current imemaddr is looked up again.
// Optional macro ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state, state_nxt;
  logic [NSETS-1:0] valid;
  logic [TW-1:0]    tags [NSETS];
  logic [31:0]      data [NSETS];

  // latched word address of the outstanding miss: {tag, index}
  logic [29:0]      lat_addr, lat_addr_nxt;
  logic             fill;
  logic             miss_start;

  logic [IW-1:0]    idx;
  logic [TW-1:0]    tag;
  logic [IW-1:0]    fill_idx;
  logic [TW-1:0]    fill_tag;
  logic             unused_offset;

  assign idx           = bus.imemaddr[IW+1:2];
  assign tag           = bus.imemaddr[31:IW+2];
  assign fill_idx      = lat_addr[IW-1:0];
  assign fill_tag      = lat_addr[29:IW];
  assign unused_offset = ^bus.imemaddr[1:0];

  // FSM state, miss address and valid bits; reset abandons any fill in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      lat_addr <= '0;
      valid    <= '0;
    end else begin
      state    <= state_nxt;
      lat_addr <= lat_addr_nxt;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  // tag/data arrays are only written by a completed fill and carry no reset
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= bus.iload;
    end
  end

  // next-state, lookup and arbiter-request decode
  always_comb begin
    state_nxt    = state;
    lat_addr_nxt = lat_addr;
    fill         = 1'b0;
    miss_start   = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = 32'h0;
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'h0;
    case (state)
      IDLE: begin
        if (bus.imemREN) begin
          if (valid[idx] && (tags[idx] == tag)) begin
            bus.ihit     = 1'b1;
            bus.imemload = data[idx];
          end else begin
            lat_addr_nxt = bus.imemaddr[31:2];
            state_nxt    = FETCH;
            miss_start   = 1'b1;
          end
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {lat_addr, 2'b00};
        if (!bus.iwait) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  // hit/miss event counters, wrapping modulo 2^32
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit)  hit_count  <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (NSETS=16): cold miss timing, repeat hit,
// conflict eviction, redirect during a fill, reset during a fill, and the
// optional counters when ICACHE_STATS_EN is defined.
module tb_icache;
  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;

  icache_if u_if ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.NSETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (u_if)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  // one-cycle miss fill of addr with word w (arbiter answers at once)
  task automatic fill_now(input logic [31:0] addr, input logic [31:0] w, input string name);
    u_if.imemREN = 1'b1; u_if.imemaddr = addr; u_if.iwait = 1'b1;
    #2; chk1({name, "_miss"}, u_if.ihit, 1'b0);
    tick();
    u_if.iwait = 1'b0; u_if.iload = w;
    #2; chk({name, "_iaddr"}, u_if.iaddr, {addr[31:2], 2'b00});
    tick();
    u_if.iwait = 1'b1;
    #2; chk1({name, "_hit"}, u_if.ihit, 1'b1);
    chk({name, "_load"}, u_if.imemload, w);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nRST  = 1'b0;
    u_if.imemREN  = 1'b0;
    u_if.imemaddr = 32'h0;
    u_if.iwait    = 1'b1;
    u_if.iload    = 32'hDEAD_BEEF;

    // reset state
    #12;
    chk1("rst_ihit", u_if.ihit, 1'b0);
    chk("rst_load", u_if.imemload, 32'h0);
    chk1("rst_iREN", u_if.iREN, 1'b0);
    chk("rst_iaddr", u_if.iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hitcnt", hit_count, 32'd0);
    chk("rst_misscnt", miss_count, 32'd0);
`endif
    tick();
    nRST = 1'b1;
    tick();

    // cold miss on 0x40, 3 wait cycles, ihit 5 cycles after request
    u_if.imemREN = 1'b1; u_if.imemaddr = 32'h40;
    #2; chk1("cold_c0_ihit", u_if.ihit, 1'b0);
    chk1("cold_c0_iREN", u_if.iREN, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      #2; chk1("cold_wait_iREN", u_if.iREN, 1'b1);
      chk("cold_wait_iaddr", u_if.iaddr, 32'h40);
      chk1("cold_wait_ihit", u_if.ihit, 1'b0);
    end
    tick();
    u_if.iwait = 1'b0; u_if.iload = 32'h2401_0005;
    #2; chk1("cold_c4_iREN", u_if.iREN, 1'b1);
    chk("cold_c4_iaddr", u_if.iaddr, 32'h40);
    tick();
    u_if.iwait = 1'b1; u_if.iload = 32'hDEAD_BEEF;
    #2; chk1("cold_c5_ihit", u_if.ihit, 1'b1);
    chk("cold_c5_load", u_if.imemload, 32'h2401_0005);
    chk1("cold_c5_iREN", u_if.iREN, 1'b0);
    chk("cold_c5_iaddr", u_if.iaddr, 32'h0);

    // repeat hit on 0x42 (same word) for 3 cycles
    u_if.imemaddr = 32'h42;
    for (int c = 0; c < 3; c++) begin
      tick();
      #2; chk1("rep_ihit", u_if.ihit, 1'b1);
      chk("rep_load", u_if.imemload, 32'h2401_0005);
      chk1("rep_iREN", u_if.iREN, 1'b0);
    end
`ifdef ICACHE_STATS_EN
    tick();
    u_if.imemREN = 1'b0;
    #2; chk("stats_hit", hit_count, 32'd4);
    chk("stats_miss", miss_count, 32'd1);
`endif

    // no request -> no hit even for a cached address
    u_if.imemREN = 1'b0; u_if.imemaddr = 32'h40;
    #2; chk1("noreq_ihit", u_if.ihit, 1'b0);
    chk("noreq_load", u_if.imemload, 32'h0);
    tick();

    // second index line, then conflict on index 0
    fill_now(32'h44, 32'hAAAA_5555, "idx1");
    tick();
    fill_now(32'h80, 32'h1111_2222, "conf80");
    tick();
    fill_now(32'h40, 32'h2401_0005, "refill40");
    tick();
    u_if.imemaddr = 32'h44;
    #2; chk1("idx1_kept_hit", u_if.ihit, 1'b1);
    chk("idx1_kept_load", u_if.imemload, 32'hAAAA_5555);
    u_if.imemaddr = 32'h80;
    #2; chk1("conf80_evicted", u_if.ihit, 1'b0);
    u_if.imemaddr = 32'h44;
    tick();

    // redirect during fill: 0x100 miss, PC moves to 0x200 while waiting
    u_if.imemaddr = 32'h100;
    #2; chk1("redir_miss", u_if.ihit, 1'b0);
    tick();
    u_if.imemaddr = 32'h200;
    #2; chk("redir_iaddr1", u_if.iaddr, 32'h100);
    chk1("redir_ihit_fetch", u_if.ihit, 1'b0);
    tick();
    u_if.iwait = 1'b0; u_if.iload = 32'h3333_4444;
    #2; chk("redir_iaddr2", u_if.iaddr, 32'h100);
    tick();
    u_if.iwait = 1'b1;
    u_if.imemaddr = 32'h100;
    #2; chk1("redir_100_hit", u_if.ihit, 1'b1);
    chk("redir_100_load", u_if.imemload, 32'h3333_4444);
    u_if.imemaddr = 32'h200;
    #2; chk1("redir_200_miss", u_if.ihit, 1'b0);
    chk1("redir_idle_iREN", u_if.iREN, 1'b0);
    tick();
    #2; chk1("redir_200_iREN", u_if.iREN, 1'b1);
    chk("redir_200_iaddr", u_if.iaddr, 32'h200);
    u_if.iwait = 1'b0; u_if.iload = 32'h5555_6666;
    tick();
    u_if.iwait = 1'b1;
    #2; chk("redir_200_load", u_if.imemload, 32'h5555_6666);
    tick();

    // reset during fill of 0x84
    u_if.imemaddr = 32'h84;
    tick();
    #1; chk1("rstmid_iREN_before", u_if.iREN, 1'b1);
    nRST = 1'b0;
    #1; chk1("rstmid_iREN", u_if.iREN, 1'b0);
    chk("rstmid_iaddr", u_if.iaddr, 32'h0);
    u_if.iwait = 1'b0; u_if.iload = 32'h7777_8888;
    tick();
    u_if.iwait = 1'b1;
    nRST = 1'b1;
    #2; chk1("rstmid_84_miss", u_if.ihit, 1'b0);
    u_if.imemaddr = 32'h44;
    #2; chk1("rstmid_44_invalid", u_if.ihit, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("rstmid_hitcnt", hit_count, 32'd0);
`endif
    u_if.imemREN = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
